// File: rtl/matrix_scan.sv
// 4x4 keyboard matrix scanner: walks active-low rows, samples synchronised columns,
// and debounces the 16-bit active-low key map over whole scan frames.
module matrix_scan #(
    parameter int CLK_DIV    = 100000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic        clk_100M,
    input  logic        rst_p,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_num,
    output logic        en
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_N);

    logic [3:0]       col_m;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [11:0]      frame;
    logic [15:0]      cand;
    logic [3:0]       stable_cnt;

    logic             tick;
    logic [15:0]      frame_full;
    logic [3:0]       cnt_next;

    assign tick       = (div == DIV_LAST);
    // Row 3 is never stored; its columns are taken live at the closing tick.
    assign frame_full = {col_s, frame};

    always_comb begin
        cnt_next = 4'd1;
        if (frame_full == cand) begin
            cnt_next = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            col_m      <= 4'hF;
            col_s      <= 4'hF;
            div        <= '0;
            row_idx    <= 2'd0;
            row        <= 4'b1110;
            frame      <= 12'hFFF;
            cand       <= 16'hFFFF;
            stable_cnt <= 4'd0;
            key_num    <= 16'hFFFF;
            en         <= 1'b0;
        end else begin
            col_m <= col;
            col_s <= col_m;
            en    <= 1'b0;

            if (tick) begin
                div     <= '0;
                row_idx <= row_idx + 2'd1;
                row     <= {row[2:0], row[3]};
                case (row_idx)
                    2'd0:    frame[3:0]  <= col_s;
                    2'd1:    frame[7:4]  <= col_s;
                    2'd2:    frame[11:8] <= col_s;
                    default: begin
                        if (frame_full != cand) cand <= frame_full;
                        stable_cnt <= cnt_next;
                        if (cnt_next >= DEB_N) key_num <= frame_full;
                        en <= 1'b1;
                    end
                endcase
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan with CLK_DIV=4, DEBOUNCE_N=2 and a behavioural key matrix.
module tb_matrix_scan;

    logic        clk_100M = 1'b0;
    logic        rst_p;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_num;
    logic        en;

    logic [15:0] key_map;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_cyc;
    logic [3:0]  row_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    matrix_scan #(.CLK_DIV(4), .DEBOUNCE_N(2)) dut (
        .clk_100M (clk_100M),
        .rst_p    (rst_p),
        .col      (col),
        .row      (row),
        .key_num  (key_num),
        .en       (en)
    );

    always #5 clk_100M = ~clk_100M;

    // A pressed key shorts its column to its row; only the driven (low) row pulls columns down.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & key_map[r*4 +: 4];
        end
    end

    task automatic step();
        @(posedge clk_100M);
        @(negedge clk_100M);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (en !== 1'b1 && n < 64);
        check("en_seen", {15'd0, en}, 16'h0001);
    endtask

    initial begin
        rst_p   = 1'b1;
        key_map = 16'hFFFF;
        @(negedge clk_100M);
        repeat (3) step();
        check("rst_row", {12'd0, row}, 16'h000E);
        check("rst_key", key_num, 16'hFFFF);
        check("rst_en", {15'd0, en}, 16'h0000);
        rst_p = 1'b0;

        // Idle scan: row walk and en every 16 cycles
        for (int k = 1; k <= 32; k++) begin
            step();
            check("idle_row", {12'd0, row}, {12'd0, row_tab[(k / 4) % 4]});
            check("idle_en", {15'd0, en}, (k % 16 == 0) ? 16'h0001 : 16'h0000);
            if (k % 16 == 0) check("idle_key", key_num, 16'hFFFF);
        end

        // Key 6 pressed from a frame boundary
        key_map = 16'hFFBF;
        wait_en(n_cyc);
        check("press_period", 16'(n_cyc), 16'd16);
        check("press_f1", key_num, 16'hFFFF);
        wait_en(n_cyc);
        check("press_f2", key_num, 16'hFFBF);

        // Release
        key_map = 16'hFFFF;
        wait_en(n_cyc);
        check("release_f1", key_num, 16'hFFBF);
        wait_en(n_cyc);
        check("release_f2", key_num, 16'hFFFF);

        // Bounce on alternate frames never reaches two identical frames
        for (int f = 0; f < 6; f++) begin
            key_map = (f % 2 == 0) ? 16'hFFBF : 16'hFFFF;
            wait_en(n_cyc);
            check("bounce_period", 16'(n_cyc), 16'd16);
            check("bounce_key", key_num, 16'hFFFF);
        end

        // Keys 0 and 15 together, then held long enough to saturate the counter
        key_map = 16'h7FFE;
        wait_en(n_cyc);
        check("multi_f1", key_num, 16'hFFFF);
        wait_en(n_cyc);
        check("multi_f2", key_num, 16'h7FFE);
        for (int f = 0; f < 16; f++) begin
            wait_en(n_cyc);
            check("multi_hold", key_num, 16'h7FFE);
        end

        // Key 6 stable, then reset during the row-2 slot
        key_map = 16'hFFBF;
        wait_en(n_cyc);
        check("k6_f1", key_num, 16'h7FFE);
        wait_en(n_cyc);
        check("k6_f2", key_num, 16'hFFBF);
        repeat (9) step();
        check("midrst_row2", {12'd0, row}, 16'h000B);
        rst_p = 1'b1;
        step();
        check("midrst_key", key_num, 16'hFFFF);
        check("midrst_row", {12'd0, row}, 16'h000E);
        check("midrst_en", {15'd0, en}, 16'h0000);
        rst_p = 1'b0;
        wait_en(n_cyc);
        check("reacq_first_en", 16'(n_cyc), 16'd16);
        check("reacq_f1", key_num, 16'hFFFF);
        wait_en(n_cyc);
        check("reacq_f2", key_num, 16'hFFBF);
        step();
        check("en_one_cycle", {15'd0, en}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
